// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - multi-cycle restoring integer divider (quotient to LO, remainder to HI)
//
// One quotient bit is produced per clock. A divide takes WIDTH+3 edges from
// the accepting start edge to the cycle where done is high; a zero divisor
// finishes after a single preparation edge.
//
// Build option: define DIV_SIGNED_EN to honour signed_op (two's-complement
// divide, quotient truncated toward zero, remainder carries the dividend's
// sign). Without it every operation is unsigned and signed_op is ignored.
//
// Ports:
//   clock      in   rising-edge clock
//   clear      in   synchronous active-high reset, aborts any divide in flight
//   start      in   divide request, sampled only while idle
//   signed_op  in   1 = signed divide (DIV_SIGNED_EN builds only)
//   dividend   in   WIDTH  numerator, captured on the accepted start edge
//   divisor    in   WIDTH  denominator, captured on the accepted start edge
//   busy       out  divide in progress
//   done       out  one-cycle pulse, results valid
//   dz         out  divide-by-zero flag, valid with done, held until next start
//   quotient   out  WIDTH  result to LO
//   remainder  out  WIDTH  result to HI
//   z_out      out  2*WIDTH  {remainder, quotient}

module seq_divider #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clock,
  input  logic               clear,
  input  logic               start,
  input  logic               signed_op,
  input  logic [WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               busy,
  output logic               done,
  output logic               dz,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic [2*WIDTH-1:0] z_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_ITER,
    S_FIX,
    S_DONE
  } state_t;

  state_t             state_q;
  // dvd_q holds the dividend magnitude and, as it shifts out, collects the
  // quotient bits in its LSBs; after WIDTH steps it is the quotient magnitude.
  logic [WIDTH-1:0]   dvd_q;
  logic [WIDTH-1:0]   dsr_q;
  logic [WIDTH-1:0]   rem_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   quo_out_q;
  logic [WIDTH-1:0]   rem_out_q;
  logic               busy_q;
  logic               done_q;
  logic               dz_q;

  // One restoring step: the shifted partial remainder needs WIDTH+1 bits.
  logic [WIDTH:0]     shift_d;
  logic               fits_d;
  logic [WIDTH-1:0]   trial_d;

  always_comb begin
    shift_d = {rem_q, dvd_q[WIDTH-1]};
    fits_d  = shift_d >= {1'b0, dsr_q};
    // When the subtraction is kept the true difference is below the divisor,
    // so the low WIDTH bits of the shifted value give the exact result.
    trial_d = shift_d[WIDTH-1:0] - dsr_q;
  end

  logic [WIDTH-1:0]   dvd_prep_d;
  logic [WIDTH-1:0]   dsr_prep_d;
  logic [WIDTH-1:0]   quo_fix_d;
  logic [WIDTH-1:0]   rem_fix_d;

`ifdef DIV_SIGNED_EN
  logic sgn_q;
  logic qneg_q;
  logic rneg_q;

  always_comb begin
    dvd_prep_d = (sgn_q && dvd_q[WIDTH-1]) ? -dvd_q : dvd_q;
    dsr_prep_d = (sgn_q && dsr_q[WIDTH-1]) ? -dsr_q : dsr_q;
    // MIN / -1: magnitude quotient is 2**(WIDTH-1) with no negation, which
    // reads back as MIN again -- the intended wrap.
    quo_fix_d  = qneg_q ? -dvd_q : dvd_q;
    rem_fix_d  = rneg_q ? -rem_q : rem_q;
  end
`else
  logic unused_signed_op;
  assign unused_signed_op = signed_op;

  always_comb begin
    dvd_prep_d = dvd_q;
    dsr_prep_d = dsr_q;
    quo_fix_d  = dvd_q;
    rem_fix_d  = rem_q;
  end
`endif

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q   <= S_IDLE;
      dvd_q     <= '0;
      dsr_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      quo_out_q <= '0;
      rem_out_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
`ifdef DIV_SIGNED_EN
      sgn_q     <= 1'b0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            dvd_q   <= dividend;
            dsr_q   <= divisor;
            busy_q  <= 1'b1;
            dz_q    <= 1'b0;
`ifdef DIV_SIGNED_EN
            sgn_q   <= signed_op;
`endif
            state_q <= S_PREP;
          end
        end

        S_PREP: begin
          rem_q <= '0;
          cnt_q <= '0;
`ifdef DIV_SIGNED_EN
          qneg_q <= sgn_q && (dvd_q[WIDTH-1] ^ dsr_q[WIDTH-1]);
          rneg_q <= sgn_q && dvd_q[WIDTH-1];
`endif
          if (dsr_q == '0) begin
            // Raw (unsigned-view) dividend goes to HI regardless of mode.
            quo_out_q <= '1;
            rem_out_q <= dvd_q;
            dz_q      <= 1'b1;
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= S_DONE;
          end else begin
            dvd_q   <= dvd_prep_d;
            dsr_q   <= dsr_prep_d;
            state_q <= S_ITER;
          end
        end

        S_ITER: begin
          rem_q <= fits_d ? trial_d : shift_d[WIDTH-1:0];
          dvd_q <= {dvd_q[WIDTH-2:0], fits_d};
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_q <= S_FIX;
          end
        end

        S_FIX: begin
          quo_out_q <= quo_fix_d;
          rem_out_q <= rem_fix_d;
          done_q    <= 1'b1;
          dz_q      <= 1'b0;
          busy_q    <= 1'b0;
          state_q   <= S_DONE;
        end

        S_DONE: begin
          // start seen here is deliberately dropped; it is picked up once idle.
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign dz        = dz_q;
  assign quotient  = quo_out_q;
  assign remainder = rem_out_q;
  assign z_out     = {rem_out_q, quo_out_q};

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - scoreboard bench for seq_divider (WIDTH=32)

module tb_seq_divider;

  localparam int W = 32;

`ifdef DIV_SIGNED_EN
  localparam bit SGN_EN = 1'b1;
`else
  localparam bit SGN_EN = 1'b0;
`endif

  logic           clock = 1'b0;
  logic           clear;
  logic           start;
  logic           signed_op;
  logic [W-1:0]   dividend;
  logic [W-1:0]   divisor;
  logic           busy;
  logic           done;
  logic           dz;
  logic [W-1:0]   quotient;
  logic [W-1:0]   remainder;
  logic [2*W-1:0] z_out;

  seq_divider #(.WIDTH(W), .CNT_W(6)) dut (
    .clock     (clock),
    .clear     (clear),
    .start     (start),
    .signed_op (signed_op),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .dz        (dz),
    .quotient  (quotient),
    .remainder (remainder),
    .z_out     (z_out)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  int exp_done = 0;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           acc;
  } exp_t;

  exp_t sb[$];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, want);
    end
  endtask

  // Result monitor: every done pulse must match the oldest pending expectation.
  always @(negedge clock) begin
    exp_t e;
    if (done === 1'b1) begin
      done_cnt++;
      if (sb.size() == 0) begin
        check("spurious_done", 1, 0);
      end else begin
        e = sb.pop_front();
        check("quotient", quotient, e.q);
        check("remainder", remainder, e.r);
        check("z_out", z_out, {e.r, e.q});
        check("dz", dz, e.dz);
        check("busy_at_done", busy, 0);
        check("latency", cyc - e.acc, e.dz ? 1 : W + 2);
      end
    end
  end

  function automatic logic [2*W:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    logic na, nb;
    logic [W-1:0] ma, mb, q, r;
    if (b == '0) return {1'b1, a, {W{1'b1}}};
    na = s && SGN_EN && a[W-1];
    nb = s && SGN_EN && b[W-1];
    ma = na ? -a : a;
    mb = nb ? -b : b;
    q = ma / mb;
    r = ma % mb;
    if (na ^ nb) q = -q;
    if (na) r = -r;
    return {1'b0, r, q};
  endfunction

  task automatic push_exp(input logic [W-1:0] q, input logic [W-1:0] r, input logic edz, input int acc);
    exp_t e;
    e.q = q;
    e.r = r;
    e.dz = edz;
    e.acc = acc;
    sb.push_back(e);
    exp_done++;
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz);
    @(negedge clock);
    dividend = a;
    divisor = b;
    signed_op = s;
    start = 1'b1;
    push_exp(eq, er, edz, cyc + 1);
    @(negedge clock);
    start = 1'b0;
    dividend = $urandom;
    divisor = $urandom;
    check("busy_after_start", busy, 1);
  endtask

  task automatic issue_m(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    logic [2*W:0] m;
    m = model(a, b, s);
    issue(a, b, s, m[W-1:0], m[2*W-1:W], m[2*W]);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clock);
    if (sb.size() != 0) begin
      check("timeout", sb.size(), 0);
      sb.delete();
    end
    @(negedge clock);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    clear = 1'b1;
    start = 1'b0;
    signed_op = 1'b0;
    dividend = '0;
    divisor = '0;
    repeat (3) @(negedge clock);
    clear = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dz", dz, 0);
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_z_out", z_out, 0);

    issue(32'h12, 32'h4, 1'b0, 32'h4, 32'h2, 1'b0);
    wait_idle();

`ifdef DIV_SIGNED_EN
    issue(32'hFFFFFFF9, 32'h2, 1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0);
`else
    issue(32'hFFFFFFF9, 32'h2, 1'b1, 32'h7FFFFFFC, 32'h1, 1'b0);
`endif
    wait_idle();
    issue(32'hFFFFFFF9, 32'h2, 1'b0, 32'h7FFFFFFC, 32'h1, 1'b0);
    wait_idle();

    issue(32'h18, 32'h0, 1'b0, 32'hFFFFFFFF, 32'h18, 1'b1);
    wait_idle();
    check("dz_held", dz, 1);

`ifdef DIV_SIGNED_EN
    issue(32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'h0, 1'b0);
`else
    issue(32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h0, 32'h80000000, 1'b0);
`endif
    wait_idle();

    // Abort in flight; previous result must still be on the outputs until then.
    issue(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0);
    repeat (9) @(negedge clock);
    check("hold_z_out", z_out, SGN_EN ? 64'h00000000_80000000 : 64'h80000000_00000000);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    sb.delete();
    exp_done--;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_z_out", z_out, 0);
    check("abort_dz", dz, 0);
    repeat (45) @(negedge clock);
    issue(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0);
    wait_idle();

    // A second start mid-operation must be ignored.
    issue(32'd1000, 32'd3, 1'b0, 32'd333, 32'd1, 1'b0);
    repeat (3) @(negedge clock);
    dividend = 32'd50;
    divisor = 32'd5;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_idle();
    repeat (40) @(negedge clock);

    // start held through the DONE cycle is only accepted once back in IDLE.
    issue(32'h12345678, 32'h10, 1'b0, 32'h01234567, 32'h8, 1'b0);
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 60 && !seen; i++) begin
        @(negedge clock);
        if (done === 1'b1) seen = 1'b1;
      end
      check("b2b_done_seen", seen, 1);
      dividend = 32'hFFFFFFFF;
      divisor = 32'h0000FFFF;
      signed_op = 1'b0;
      start = 1'b1;
      push_exp(32'h00010001, 32'h0, 1'b0, cyc + 2);
      @(negedge clock);
      @(negedge clock);
      start = 1'b0;
    end
    wait_idle();

    for (int i = 0; i < 8; i++) begin
      logic [W-1:0] a, b;
      logic s;
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      if (i == 3) b = '0;
      s = 1'b1 & $urandom_range(0, 1);
      issue_m(a, b, s);
      wait_idle();
    end

    repeat (5) @(negedge clock);
    check("done_count", done_cnt, exp_done);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
